// File: rtl/word_subtractor_if.sv
// Control and operand-memory bus of the multi-word subtractor.
// The subtractor drives the master side; the comparator/memory environment drives the slave side.
interface word_subtractor_if #(
  parameter int DATA_WIDTH = 32
);
  // Handshake: sub_start is taken only while busy is low, and sub_ok/index_reset pulse once when
  // the job ends. Read data returns the cycle after data_r_en; a write is performed on every data_w_en cycle.
  logic                  sub_start;
  logic                  compare_result;
  logic                  data_r_en;
  logic [31:0]           data_addr;
  logic [DATA_WIDTH-1:0] read_data1;
  logic [DATA_WIDTH-1:0] read_data2;
  logic                  data_w_en;
  logic [31:0]           write_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  borrow_out;
  logic                  busy;
  logic                  sub_ok;
  logic                  index_reset;
  logic [1:0]            dbg_state;

  modport master (
    input  sub_start, compare_result, read_data1, read_data2,
    output data_r_en, data_addr, data_w_en, write_addr, write_data,
    output borrow_out, busy, sub_ok, index_reset, dbg_state
  );

  modport slave (
    output sub_start, compare_result, read_data1, read_data2,
    input  data_r_en, data_addr, data_w_en, write_addr, write_data,
    input  borrow_out, busy, sub_ok, index_reset, dbg_state
  );
endinterface

// File: rtl/word_subtractor.sv
// Computes A - B word by word (LSW first) over two operand memories, writing the result back into A.
// The borrow ripples between words through a register; the final borrow is exposed once the job is done.
module word_subtractor #(
  parameter int          DATA_WIDTH = 32,
  parameter int unsigned NUM_WORDS  = 32
) (
  input logic               CLK,
  input logic               RST,
  word_subtractor_if.master bus
);
  localparam logic [31:0] LAST_ADDR = 32'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic                r_en_q, r_en_d;
  logic [31:0]         addr_q, addr_d;
  logic                w_en_q;
  logic [31:0]         waddr_q;
  logic                borrow_q;
  logic [DATA_WIDTH:0] sub_full;

  // One extra bit: its MSB is set exactly when read_data1 < read_data2 + borrow.
  assign sub_full = {1'b0, bus.read_data1} - {1'b0, bus.read_data2}
                  - {{DATA_WIDTH{1'b0}}, borrow_q};

  always_comb begin
    state_d = state_q;
    r_en_d  = 1'b0;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (bus.sub_start) begin
          if (bus.compare_result) begin
            state_d = RUN;
            r_en_d  = 1'b1;
            addr_d  = '0;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (addr_q == LAST_ADDR) begin
          state_d = DRAIN;
        end else begin
          r_en_d = 1'b1;
          addr_d = addr_q + 32'd1;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      r_en_q   <= 1'b0;
      addr_q   <= '0;
      w_en_q   <= 1'b0;
      waddr_q  <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      r_en_q  <= r_en_d;
      addr_q  <= addr_d;
      w_en_q  <= r_en_q;
      waddr_q <= addr_q;
      if (state_q == IDLE && bus.sub_start) begin
        borrow_q <= 1'b0;
      end else if (w_en_q) begin
        borrow_q <= sub_full[DATA_WIDTH];
      end
    end
  end

  assign bus.data_r_en   = r_en_q;
  assign bus.data_addr   = addr_q;
  assign bus.data_w_en   = w_en_q;
  assign bus.write_addr  = waddr_q;
  assign bus.write_data  = sub_full[DATA_WIDTH-1:0];
  assign bus.borrow_out  = borrow_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.sub_ok      = (state_q == DONE);
  assign bus.index_reset = (state_q == DONE);
  assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_word_subtractor.sv
// Bench for word_subtractor: operand memories, a wide-integer reference model feeding expected
// queues, and a monitor that checks every write and done pulse against them.
module tb_word_subtractor;
  localparam int DW = 32;
  localparam int NW = 4;
  localparam int AW = $clog2(NW);
  localparam int VW = NW * DW;

  logic CLK = 1'b0;
  logic RST;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   t0;

  logic [95:0] wr_exp_q[$];    // {cycle, addr, data}
  logic [63:0] done_exp_q[$];  // {cycle, 31'b0, borrow}

  logic          load_req;
  logic [VW-1:0] load_av, load_bv;
  logic [DW-1:0] mem_a[NW];
  logic [DW-1:0] mem_b[NW];

  word_subtractor_if #(.DATA_WIDTH(DW)) bus ();

  word_subtractor #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.master)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- operand memories ----------------
  always @(posedge CLK) begin
    if (load_req) begin
      for (int i = 0; i < NW; i++) begin
        mem_a[i] <= load_av[i*DW +: DW];
        mem_b[i] <= load_bv[i*DW +: DW];
      end
    end else if (bus.data_w_en && bus.write_addr < NW) begin
      mem_a[bus.write_addr[AW-1:0]] <= bus.write_data;
    end
    if (bus.data_r_en && bus.data_addr < NW) begin
      bus.read_data1 <= mem_a[bus.data_addr[AW-1:0]];
      bus.read_data2 <= mem_b[bus.data_addr[AW-1:0]];
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: the operands are plain NW*DW-bit integers; the result is their difference mod 2^VW
  // and the final borrow is simply A < B.
  task automatic model_run(input logic cr, input int start_cyc, input int nwr);
    logic [VW-1:0] av, bv;
    logic [VW:0]   d;
    for (int i = 0; i < NW; i++) begin
      av[i*DW +: DW] = mem_a[i];
      bv[i*DW +: DW] = mem_b[i];
    end
    d = {1'b0, av} - {1'b0, bv};
    if (cr) begin
      for (int i = 0; i < nwr; i++)
        wr_exp_q.push_back({32'(start_cyc + 2 + i), 32'(i), d[i*DW +: DW]});
      if (nwr == NW) done_exp_q.push_back({32'(start_cyc + NW + 2), 31'b0, d[VW]});
    end else begin
      done_exp_q.push_back({32'(start_cyc + 1), 32'b0});
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge CLK) begin
    logic [95:0] we;
    logic [63:0] de;
    if (bus.data_w_en) begin
      if (wr_exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: addr %0d data %h at cycle %0d, none expected",
                 bus.write_addr, bus.write_data, cyc);
      end else begin
        we = wr_exp_q.pop_front();
        chk("write", {32'b0, 32'(cyc), bus.write_addr, bus.write_data}, {32'b0, we});
      end
    end
    if (bus.sub_ok || bus.index_reset) begin
      if (done_exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: sub_ok %b index_reset %b at cycle %0d, none expected",
                 bus.sub_ok, bus.index_reset, cyc);
      end else begin
        de = done_exp_q.pop_front();
        chk("done", {64'b0, 32'(cyc), 29'b0, bus.sub_ok, bus.index_reset, bus.borrow_out},
            {64'b0, de[63:32], 29'b0, 1'b1, 1'b1, de[0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < NW; i++) begin
      case ($urandom_range(0, 3))
        0:       v[i*DW +: DW] = '0;
        1:       v[i*DW +: DW] = '1;
        default: v[i*DW +: DW] = $urandom();
      endcase
    end
    return v;
  endfunction

  task automatic load(input logic [VW-1:0] av, input logic [VW-1:0] bv);
    load_av  = av;
    load_bv  = bv;
    load_req = 1'b1;
    @(negedge CLK);
    load_req = 1'b0;
  endtask

  // Entered at a negedge; leaves at the negedge of cycle t0+1.
  task automatic issue(input logic cr, input int nwr, output int start_cyc);
    bus.sub_start      = 1'b1;
    bus.compare_result = cr;
    start_cyc          = cyc;
    model_run(cr, start_cyc, nwr);
    @(negedge CLK);
    bus.sub_start      = 1'b0;
    bus.compare_result = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done();
    int k = 0;
    while ((wr_exp_q.size() != 0 || done_exp_q.size() != 0) && k < 60) begin
      @(negedge CLK);
      k++;
    end
    if (wr_exp_q.size() != 0 || done_exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL timeout: %0d writes and %0d done pulses still pending at cycle %0d",
               wr_exp_q.size(), done_exp_q.size(), cyc);
      wr_exp_q.delete();
      done_exp_q.delete();
    end
    @(negedge CLK);
  endtask

  function automatic logic [127:0] outs_vec();
    return {56'b0, bus.data_r_en, bus.data_w_en, bus.sub_ok, bus.index_reset,
            bus.busy, bus.borrow_out, 2'b0, bus.data_addr, bus.write_addr};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    RST                = 1'b1;
    bus.sub_start      = 1'b0;
    bus.compare_result = 1'b0;
    load_req           = 1'b0;
    load_av            = '0;
    load_bv            = '0;
    repeat (3) @(negedge CLK);
    chk("reset_outputs", outs_vec(), 128'b0);
    RST = 1'b0;
    @(negedge CLK);

    // Simple single-word difference, then a borrow that ripples through three words.
    load(128'h5, 128'h3);
    issue(1'b1, NW, t0);
    wait_done();
    load({32'h1, 96'h0}, 128'h1);
    issue(1'b1, NW, t0);
    wait_done();

    // Underflow leaves borrow_out high; the following skip must clear it.
    load(128'h0, 128'h1);
    issue(1'b1, NW, t0);
    wait_done();
    load(rand_vec(), rand_vec());
    issue(1'b0, NW, t0);
    chk("skip_busy_t0p1", {126'b0, bus.busy, bus.data_r_en}, 128'b10);
    @(negedge CLK);
    chk("skip_busy_t0p2", {126'b0, bus.busy, bus.data_r_en}, 128'b00);
    wait_done();

    // Reset during cycle t0+3 aborts after two writes, with no done pulse.
    load(128'h5, 128'h3);
    issue(1'b1, 2, t0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort_outputs", outs_vec(), 128'b0);
    repeat (10) @(negedge CLK);
    chk("abort_quiet", {64'b0, 32'(wr_exp_q.size()), 32'(done_exp_q.size())}, 128'b0);
    load(128'h5, 128'h3);
    issue(1'b1, NW, t0);
    wait_done();

    // sub_start held across a whole run: the second start is taken the cycle after sub_ok.
    load(rand_vec(), rand_vec());
    bus.sub_start      = 1'b1;
    bus.compare_result = 1'b1;
    t0                 = cyc;
    model_run(1'b1, t0, NW);
    repeat (NW + 3) @(negedge CLK);
    model_run(1'b1, t0 + NW + 3, NW);
    @(negedge CLK);
    bus.sub_start = 1'b0;
    wait_done();

    // Random operands, mostly full subtracts, with stray starts during a run.
    for (int r = 0; r < 24; r++) begin
      logic cr;
      cr = ($urandom_range(0, 3) != 0);
      load(rand_vec(), rand_vec());
      issue(cr, NW, t0);
      if (cr && $urandom_range(0, 1) == 1) begin
        @(negedge CLK);
        @(negedge CLK);
        bus.sub_start      = 1'b1;
        bus.compare_result = 1'($urandom_range(0, 1));
        @(negedge CLK);
        bus.sub_start      = 1'b0;
      end
      wait_done();
    end

    repeat (5) @(negedge CLK);
    chk("queues_drained", {64'b0, 32'(wr_exp_q.size()), 32'(done_exp_q.size())}, 128'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/word_subtractor.md
WORD_SUBTRACTOR -- requirements
Module: word_subtractor

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width of operand memories.
REQ-002 Parameter NUM_WORDS, default 32, words per operand; valid range 2..2^31.
REQ-003 CLK  input  1  single clock; all logic on rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 sub_start  input  1  start request; sampled only in IDLE.
REQ-006 compare_result  input  1  comparator verdict (1 = A > B); sampled with sub_start.
REQ-007 data_r_en  output  1  operand read enable.
REQ-008 data_addr  output  32  operand word address, shared by both memories.
REQ-009 read_data1  input  DATA_WIDTH  word of A; valid the cycle after data_r_en.
REQ-010 read_data2  input  DATA_WIDTH  word of B; valid the cycle after data_r_en.
REQ-011 data_w_en  output  1  result write enable into A memory.
REQ-012 write_addr  output  32  result word address.
REQ-013 write_data  output  DATA_WIDTH  result word.
REQ-014 borrow_out  output  1  final borrow of last subtraction.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 sub_ok  output  1  one-cycle done pulse.
REQ-017 index_reset  output  1  one-cycle pulse to comparator to reload its word index; equals sub_ok.

Function
REQ-018 States SHALL be IDLE, RUN, DRAIN, DONE; encoding free.
REQ-019 IDLE with sub_start=1 at cycle t0: latch do_sub=compare_result, clear borrow; next state RUN if do_sub=1, else DONE.
REQ-020 RUN: data_r_en=1, data_addr=0 at t0+1, incrementing by 1 each cycle, little-endian word order (addr 0 = LSW).
REQ-021 RUN SHALL last exactly NUM_WORDS cycles; after issuing address NUM_WORDS-1, next state DRAIN.
REQ-022 DRAIN: data_r_en=0, data_addr holds; next state DONE.
REQ-023 DONE: sub_ok=1, index_reset=1 for exactly one cycle; next state IDLE.
REQ-024 data_r_en and data_addr SHALL be registered outputs.
REQ-025 data_w_en SHALL equal data_r_en delayed one cycle; write_addr = data_addr delayed one cycle.
REQ-026 write_data = (read_data1 - read_data2 - borrow) mod 2^DATA_WIDTH, combinational from current read data and registered borrow.
REQ-027 On each data_w_en cycle, borrow SHALL update to 1 iff read_data1 < read_data2 + borrow (computed at DATA_WIDTH+1 bits).
REQ-028 borrow_out SHALL present registered borrow, valid from DONE until next accepted sub_start.
REQ-029 Full-subtract latency: first write at t0+2, last write at t0+NUM_WORDS+1, sub_ok at t0+NUM_WORDS+2.
REQ-030 Skip path (do_sub=0): no data_r_en or data_w_en assertion; sub_ok at t0+1; borrow_out=0.
REQ-031 sub_start outside IDLE SHALL be ignored; compare_result changes after t0 SHALL have no effect.
REQ-032 sub_start in the cycle after sub_ok (state IDLE) SHALL be accepted normally.
REQ-033 Write address SHALL never exceed NUM_WORDS-1; data_addr SHALL not wrap.

Reset
REQ-034 RST=1 at a clock edge: state IDLE; data_r_en, data_w_en, sub_ok, index_reset, busy, borrow_out = 0; data_addr, write_addr, write_data-register inputs = 0.
REQ-035 RST mid-operation SHALL abort: no data_w_en in the cycle after reset, no sub_ok for the aborted run.
REQ-036 RST SHALL take priority over sub_start in the same cycle.

Verification (NUM_WORDS=4, DATA_WIDTH=32, words listed LSW first)
REQ-037 A={5,0,0,0}, B={3,0,0,0}, compare_result=1 -> writes {2,0,0,0} at addr 0..3 on t0+2..t0+5, sub_ok at t0+6, borrow_out=0.
REQ-038 Borrow chain A={0,0,0,1}, B={1,0,0,0}, compare_result=1 -> writes {FFFFFFFF,FFFFFFFF,FFFFFFFF,0}, borrow_out=0.
REQ-039 Underflow A={0,0,0,0}, B={1,0,0,0}, compare_result=1 -> writes {FFFFFFFF x4}, borrow_out=1.
REQ-040 compare_result=0 at start -> no memory enables, sub_ok and index_reset at t0+1 only, busy high for one cycle.
REQ-041 RST pulsed at t0+3 of run in REQ-037 -> all outputs 0 next cycle, no further writes, no sub_ok; subsequent start completes normally.
REQ-042 sub_start held high during whole run -> single run, then second run accepted in cycle after sub_ok, sub_ok pulses at t0+6 and t0+13.
